// File: rtl/div_8bit_ctrl_v_if.sv
// Start/operand/result bundle for the sequential 8-bit divider.
interface div_8bit_ctrl_v_if;
  logic       i_START;
  logic [7:0] i_DIVIDEND;
  logic [7:0] i_DIVISOR;
  logic [7:0] o_Q;
  logic [7:0] o_R;
  logic       o_BUSY;
  logic       o_DONE;
  logic       o_ERR;

  modport master (
    output i_START, i_DIVIDEND, i_DIVISOR,
    input  o_Q, o_R, o_BUSY, o_DONE, o_ERR
  );

  modport slave (
    input  i_START, i_DIVIDEND, i_DIVISOR,
    output o_Q, o_R, o_BUSY, o_DONE, o_ERR
  );
endinterface

// File: rtl/div_8bit_ctrl_v.sv
// Sequential 8-bit unsigned restoring divider on one shared add/subtract unit.
// Optional macro DIV_ZERO_CHECK_EN: zero divisor short-cuts to DONE with o_ERR set.

// Single-carry-chain adder/subtractor; in subtract mode o_C is the borrow.
module addn_sub_8bit_v (
  input  logic [7:0] i_A,
  input  logic [7:0] i_B,
  input  logic       i_ADDN_SUB,
  output logic [7:0] o_S,
  output logic       o_C
);
  logic [8:0] sum;

  always_comb begin
    sum = {1'b0, i_A} + {1'b0, i_B ^ {8{i_ADDN_SUB}}} + 9'(i_ADDN_SUB);
    o_S = sum[7:0];
    o_C = sum[8] ^ i_ADDN_SUB;
  end
endmodule

module div_8bit_ctrl_v (
  input  logic              i_CLK,
  input  logic              i_RSTn,
  div_8bit_ctrl_v_if.slave  bus
);
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   r_D;
  logic [WIDTH-1:0]   r_N;
  logic [WIDTH-1:0]   r_W;
  logic [WIDTH-1:0]   r_QW;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   r_q;
  logic               busy_q;
  logic               done_q;

  logic               shift_c;
  logic [WIDTH-1:0]   trial;
  logic [WIDTH-1:0]   diff;
  logic               borrow;
  logic               qbit;
  logic [WIDTH-1:0]   w_next;

  // Shift the next dividend bit into the working remainder and trial-subtract.
  always_comb begin
    shift_c = r_W[WIDTH-1];
    trial   = {r_W[WIDTH-2:0], r_N[WIDTH-1]};
    qbit    = shift_c | ~borrow;
    w_next  = qbit ? diff : trial;
  end

  addn_sub_8bit_v u_addsub (
    .i_A        (trial),
    .i_B        (r_D),
    .i_ADDN_SUB (1'b1),
    .o_S        (diff),
    .o_C        (borrow)
  );

`ifdef DIV_ZERO_CHECK_EN
  logic err_q;
  logic r_zero;
  assign bus.o_ERR = err_q;
`else
  assign bus.o_ERR = 1'b0;
`endif

  assign bus.o_Q    = q_q;
  assign bus.o_R    = r_q;
  assign bus.o_BUSY = busy_q;
  assign bus.o_DONE = done_q;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state  <= S_IDLE;
      r_D    <= '0;
      r_N    <= '0;
      r_W    <= '0;
      r_QW   <= '0;
      r_cnt  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      err_q  <= 1'b0;
      r_zero <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_START) begin
            r_D    <= bus.i_DIVISOR;
            r_N    <= bus.i_DIVIDEND;
            r_W    <= '0;
            r_QW   <= '0;
            r_cnt  <= '0;
            busy_q <= 1'b1;
            state  <= S_CALC;
`ifdef DIV_ZERO_CHECK_EN
            err_q  <= 1'b0;
            r_zero <= (bus.i_DIVISOR == '0);
`endif
          end
        end
        S_CALC: begin
`ifdef DIV_ZERO_CHECK_EN
          if (r_zero) begin
            // r_N still holds the untouched dividend here.
            q_q    <= '1;
            r_q    <= r_N;
            err_q  <= 1'b1;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else
`endif
          begin
            r_N   <= r_N << 1;
            r_W   <= w_next;
            r_QW  <= {r_QW[WIDTH-2:0], qbit};
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              q_q    <= {r_QW[WIDTH-2:0], qbit};
              r_q    <= w_next;
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_8bit_ctrl_v.sv
// Self-checking bench: latency-based behavioural model plus directed and random divisions.
module tb_div_8bit_ctrl_v;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   chk_en = 1'b0;

  div_8bit_ctrl_v_if bus();

  div_8bit_ctrl_v dut (
    .i_CLK  (clk),
    .i_RSTn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: result is N/D, N%D, published a fixed number of edges after the start.
  logic [7:0] m_q = '0, m_r = '0, m_pq = '0, m_pr = '0;
  logic       m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0, m_perr = 1'b0;
  int         m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q = '0; m_r = '0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (m_left > 0) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_q = m_pq; m_r = m_pr; m_err = m_perr; m_done = 1'b1;
          end
        end else begin
          m_busy = 1'b0;
        end
      end else if (bus.i_START) begin
        m_busy = 1'b1;
        m_err  = 1'b0;
        m_perr = 1'b0;
        m_left = 8;
        if (bus.i_DIVISOR == 8'd0) begin
          m_pq = 8'hFF;
          m_pr = bus.i_DIVIDEND;
`ifdef DIV_ZERO_CHECK_EN
          m_perr = 1'b1;
          m_left = 1;
`endif
        end else begin
          m_pq = bus.i_DIVIDEND / bus.i_DIVISOR;
          m_pr = bus.i_DIVIDEND % bus.i_DIVISOR;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_q",    32'(bus.o_Q),    32'(m_q));
      chk("cyc_r",    32'(bus.o_R),    32'(m_r));
      chk("cyc_busy", 32'(bus.o_BUSY), 32'(m_busy));
      chk("cyc_done", 32'(bus.o_DONE), 32'(m_done));
      chk("cyc_err",  32'(bus.o_ERR),  32'(m_err));
    end
  end

  task automatic do_start(input logic [7:0] n, input logic [7:0] d);
    @(negedge clk); #1;
    bus.i_START = 1'b1; bus.i_DIVIDEND = n; bus.i_DIVISOR = d;
    @(negedge clk); #1;
    bus.i_START = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [7:0] eq, input logic [7:0] er,
                           input logic ee);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.o_DONE) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_q"},   32'(bus.o_Q),   32'(eq));
      chk({name, "_r"},   32'(bus.o_R),   32'(er));
      chk({name, "_err"}, 32'(bus.o_ERR), 32'(ee));
    end
    for (int i = 0; i < 5 && bus.o_BUSY; i++) @(negedge clk);
    chk({name, "_idle"}, 32'(bus.o_BUSY), 32'd0);
  endtask

  task automatic run(input string name, input logic [7:0] n, input logic [7:0] d,
                     input logic [7:0] eq, input logic [7:0] er);
    do_start(n, d);
    wait_done(name, eq, er, 1'b0);
  endtask

  initial begin
    logic [7:0] rn, rd;
    bit         seen;
    bus.i_START = 1'b0; bus.i_DIVIDEND = '0; bus.i_DIVISOR = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_q", 32'(bus.o_Q), 32'd0);
    chk("rst_r", 32'(bus.o_R), 32'd0);
    chk("rst_busy", 32'(bus.o_BUSY), 32'd0);
    chk("rst_done", 32'(bus.o_DONE), 32'd0);
    chk("rst_err", 32'(bus.o_ERR), 32'd0);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    run("d200_7", 8'd200, 8'd7, 8'd28, 8'd4);
    run("d255_1", 8'd255, 8'd1, 8'd255, 8'd0);
    run("d5_9", 8'd5, 8'd9, 8'd0, 8'd5);
    run("d255_255", 8'd255, 8'd255, 8'd1, 8'd0);
    run("d128_200", 8'd128, 8'd200, 8'd0, 8'd128);

    // Divide by zero.
    do_start(8'h5A, 8'd0);
`ifdef DIV_ZERO_CHECK_EN
    wait_done("dz", 8'hFF, 8'h5A, 1'b1);
`else
    wait_done("dz", 8'hFF, 8'h5A, 1'b0);
`endif

    // Starts while busy (CALC and DONE) are ignored.
    do_start(8'd100, 8'd3);
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.o_DONE) begin
        seen = 1'b1;
        chk("ign_q", 32'(bus.o_Q), 32'd33);
        chk("ign_r", 32'(bus.o_R), 32'd1);
      end
      #1;
      bus.i_START = (k == 3 || k == 8);
      bus.i_DIVIDEND = 8'd50; bus.i_DIVISOR = 8'd5;
    end
    bus.i_START = 1'b0;
    chk("ign_seen", 32'(seen), 32'd1);
    run("d50_5", 8'd50, 8'd5, 8'd10, 8'd0);

    // Reset mid-operation.
    do_start(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_q", 32'(bus.o_Q), 32'd0);
    chk("abort_r", 32'(bus.o_R), 32'd0);
    chk("abort_busy", 32'(bus.o_BUSY), 32'd0);
    chk("abort_done", 32'(bus.o_DONE), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run("d9_2", 8'd9, 8'd2, 8'd4, 8'd1);

    // Random regression, nonzero divisors.
    for (int i = 0; i < 1000; i++) begin
      rn = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(1, 255));
      run("rand", rn, rd, rn / rd, rn % rd);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
